// File: rtl/axis_elastic_buffer.sv
// -----------------------------------------------------------------------------
// axis_elastic_buffer
//
// Ring-buffer elastic stage for a valid/ready stream. Decouples upstream and
// downstream handshakes with DEPTH entries of storage. With OUT_REG=1 the
// output is always driven from storage (no combinational path from the input
// side to o_valid/o_data). With OUT_REG=0 an empty buffer lets a beat fall
// straight through in the same cycle; it is stored only if downstream stalls.
//
// Parameters
//   DW       payload width in bits (>=1)
//   DEPTH    number of storage entries (power of two, >=2)
//   OUT_REG  1 = registered output, 0 = fall-through when empty
//
// Ports
//   i_clk    clock, all state updates on the rising edge
//   i_reset  synchronous, active-low reset
//   i_flush  synchronous discard of all stored beats
//   i_valid  upstream beat valid        o_ready  buffer can accept a beat
//   i_data   upstream payload
//   o_valid  downstream beat valid      i_ready  downstream accepts beat
//   o_data   downstream payload
//   o_count  number of stored beats
// -----------------------------------------------------------------------------
module axis_elastic_buffer #(
  parameter int DW      = 8,
  parameter int DEPTH   = 2,
  parameter int OUT_REG = 1
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic                       i_flush,
  input  logic                       i_valid,
  output logic                       o_ready,
  input  logic [DW-1:0]              i_data,
  output logic                       o_valid,
  input  logic                       i_ready,
  output logic [DW-1:0]              o_data,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
  localparam logic [AW-1:0] LAST_PTR   = AW'(DEPTH - 1);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;

  logic active;   // out of reset and not flushing
  logic empty;
  logic ft_mode;  // fall-through path selected this cycle
  logic push;
  logic pop;

  // ---------------------------------------------------------------------------
  // Handshake and datapath selection
  // ---------------------------------------------------------------------------
  // NOTE: every signal written here gets a value on every path through the
  // block, so no latch can be inferred.
  always_comb begin
    active  = i_reset && !i_flush;
    empty   = (count == '0);
    ft_mode = (OUT_REG == 0) && empty;

    // Depends only on stored state, reset and flush: a full buffer refuses a
    // beat even in a cycle where it is also popping.
    o_ready = (count < FULL_COUNT) && active;

    if (!active) begin
      o_valid = 1'b0;
    end else if (!empty) begin
      o_valid = 1'b1;
    end else if (OUT_REG == 0) begin
      o_valid = i_valid;
    end else begin
      o_valid = 1'b0;
    end

    o_data = ft_mode ? i_data : mem[rd_ptr];

    // A fall-through beat taken by downstream never touches storage.
    push = i_valid && o_ready && !(ft_mode && i_ready);
    pop  = o_valid && i_ready && !empty;
  end

  assign o_count = count;

  // ---------------------------------------------------------------------------
  // Pointers and occupancy
  // ---------------------------------------------------------------------------
  // NOTE: state registers use non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge i_clk) begin
    if (!i_reset || i_flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  // NOTE: the storage array is deliberately left out of reset; entries are
  // only ever read after being written, and o_data is don't-care while
  // o_valid is low.
  always_ff @(posedge i_clk) begin
    if (push) begin
      mem[wr_ptr] <= i_data;
    end
  end

endmodule

// File: tb/tb_axis_elastic_buffer.sv
// -----------------------------------------------------------------------------
// tb_axis_elastic_buffer
//
// Two instances (DW=8, DEPTH=4): dut_r with a registered output and dut_f in
// fall-through mode. The stimulus process pushes each beat it expects to be
// accepted onto a per-instance queue; a monitor per instance pops and compares
// whenever a beat is transferred downstream. Inputs change on the falling
// edge, everything is sampled 1 time unit before the rising edge.
// -----------------------------------------------------------------------------
module tb_axis_elastic_buffer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n;
  logic flush;

  logic       r_valid, r_ready, r_o_ready, r_o_valid;
  logic [7:0] r_data, r_o_data;
  logic [2:0] r_count;

  logic       f_valid, f_ready, f_o_ready, f_o_valid;
  logic [7:0] f_data, f_o_data;
  logic [2:0] f_count;

  axis_elastic_buffer #(.DW(8), .DEPTH(4), .OUT_REG(1)) dut_r (
    .i_clk   (clk),
    .i_reset (reset_n),
    .i_flush (flush),
    .i_valid (r_valid),
    .o_ready (r_o_ready),
    .i_data  (r_data),
    .o_valid (r_o_valid),
    .i_ready (r_ready),
    .o_data  (r_o_data),
    .o_count (r_count)
  );

  axis_elastic_buffer #(.DW(8), .DEPTH(4), .OUT_REG(0)) dut_f (
    .i_clk   (clk),
    .i_reset (reset_n),
    .i_flush (flush),
    .i_valid (f_valid),
    .o_ready (f_o_ready),
    .i_data  (f_data),
    .o_valid (f_o_valid),
    .i_ready (f_ready),
    .o_data  (f_o_data),
    .o_count (f_count)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0] rq[$];
  logic [7:0] fq[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic set_r(input logic v, input logic [7:0] d, input logic rdy, input logic acc);
    r_valid = v;
    r_data  = d;
    r_ready = rdy;
    if (acc) rq.push_back(d);
  endtask

  task automatic set_f(input logic v, input logic [7:0] d, input logic rdy, input logic acc);
    f_valid = v;
    f_data  = d;
    f_ready = rdy;
    if (acc) fq.push_back(d);
  endtask

  task automatic settle();
    #4;
  endtask

  task automatic next();
    @(negedge clk);
  endtask

  // Monitors: compare every downstream transfer against the expected queue.
  always begin : mon_r
    logic [7:0] exp_b;
    @(negedge clk);
    #4;
    if (r_o_valid && r_ready) begin
      if (rq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL r_unexpected_beat actual=%0h required=none (t=%0t)", r_o_data, $time);
      end else begin
        exp_b = rq.pop_front();
        check("r_beat", r_o_data, exp_b);
      end
    end
  end

  always begin : mon_f
    logic [7:0] exp_b;
    @(negedge clk);
    #4;
    if (f_o_valid && f_ready) begin
      if (fq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL f_unexpected_beat actual=%0h required=none (t=%0t)", f_o_data, $time);
      end else begin
        exp_b = fq.pop_front();
        check("f_beat", f_o_data, exp_b);
      end
    end
  end

  initial begin : watchdog
    #50000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    reset_n = 1'b0;
    flush   = 1'b0;
    set_r(1'b0, 8'h00, 1'b0, 1'b0);
    set_f(1'b1, 8'h12, 1'b1, 1'b0);  // fall-through must stay masked in reset

    // ---------------- reset and release ----------------
    repeat (2) next();
    settle();
    check("rst_r_valid", r_o_valid, 0);
    check("rst_r_ready", r_o_ready, 0);
    check("rst_f_valid", f_o_valid, 0);
    check("rst_f_ready", f_o_ready, 0);
    check("rst_r_count", r_count, 0);
    next();
    reset_n = 1'b1;
    set_f(1'b0, 8'h00, 1'b0, 1'b0);
    settle();
    check("rel_r_ready", r_o_ready, 1);
    check("rel_r_valid", r_o_valid, 0);
    check("rel_r_count", r_count, 0);
    check("rel_f_ready", f_o_ready, 1);
    next();

    // ---------------- registered streaming, one cycle latency ----------------
    set_r(1'b1, 8'h11, 1'b1, 1'b1); settle();
    check("s0_valid", r_o_valid, 0);
    check("s0_count", r_count, 0);
    next();
    set_r(1'b1, 8'h22, 1'b1, 1'b1); settle();
    check("s1_valid", r_o_valid, 1);
    check("s1_data", r_o_data, 8'h11);
    check("s1_count", r_count, 1);
    next();
    set_r(1'b1, 8'h33, 1'b1, 1'b1); settle();
    check("s2_data", r_o_data, 8'h22);
    check("s2_count", r_count, 1);
    next();
    set_r(1'b0, 8'h00, 1'b1, 1'b0); settle();
    check("s3_data", r_o_data, 8'h33);
    check("s3_count", r_count, 1);
    next();
    settle();
    check("s4_count", r_count, 0);
    check("s4_valid", r_o_valid, 0);
    next();

    // ---------------- fill to full, back-pressure, drain ----------------
    for (int i = 0; i < 4; i++) begin
      set_r(1'b1, 8'hA0 + 8'(i), 1'b0, 1'b1); settle();
      check("fill_count", r_count, 32'(i));
      check("fill_ready", r_o_ready, 1);
      next();
    end
    set_r(1'b1, 8'hA4, 1'b0, 1'b0); settle();
    check("full_count", r_count, 4);
    check("full_ready", r_o_ready, 0);
    check("full_data", r_o_data, 8'hA0);
    next();
    settle();
    check("hold_data", r_o_data, 8'hA0);
    check("hold_ready", r_o_ready, 0);
    next();
    set_r(1'b1, 8'hA4, 1'b1, 1'b0); settle();   // pops A0, push refused while full
    check("pop_full_ready", r_o_ready, 0);
    next();
    set_r(1'b1, 8'hA4, 1'b1, 1'b1); settle();   // room after first pop
    check("after_pop_ready", r_o_ready, 1);
    check("after_pop_count", r_count, 3);
    next();
    set_r(1'b0, 8'h00, 1'b1, 1'b0); settle();
    check("drain_count3", r_count, 3);
    next(); settle();
    check("drain_count2", r_count, 2);
    next(); settle();
    check("drain_count1", r_count, 1);
    next(); settle();
    check("drain_count0", r_count, 0);
    next();

    // ---------------- simultaneous push/pop across pointer wrap ----------------
    set_r(1'b1, 8'hB0, 1'b0, 1'b1); next();
    set_r(1'b1, 8'hB1, 1'b0, 1'b1); next();
    for (int i = 2; i < 5; i++) begin
      set_r(1'b1, 8'hB0 + 8'(i), 1'b1, 1'b1); settle();
      check("pp_count", r_count, 2);
      next();
    end
    set_r(1'b0, 8'h00, 1'b1, 1'b0); settle();
    check("pp_tail_count", r_count, 2);
    next(); next(); settle();
    check("pp_empty", r_count, 0);
    next();

    // ---------------- flush with stored beats ----------------
    for (int i = 0; i < 3; i++) begin
      set_r(1'b1, 8'hC0 + 8'(i), 1'b0, 1'b1); next();
    end
    flush = 1'b1;
    rq.delete();
    set_r(1'b1, 8'h77, 1'b1, 1'b0); settle();
    check("flush_valid", r_o_valid, 0);
    check("flush_ready", r_o_ready, 0);
    next();
    flush = 1'b0;
    set_r(1'b0, 8'h00, 1'b1, 1'b0); settle();
    check("flush_count", r_count, 0);
    check("flush_after_valid", r_o_valid, 0);
    next();
    set_r(1'b1, 8'hD0, 1'b1, 1'b1); next();
    set_r(1'b0, 8'h00, 1'b1, 1'b0); next(); next();

    // ---------------- reset mid-operation ----------------
    for (int i = 0; i < 3; i++) begin
      set_r(1'b1, 8'hE0 + 8'(i), 1'b0, 1'b1); next();
    end
    settle();
    check("pre_rst_count", r_count, 3);
    next();
    reset_n = 1'b0;
    rq.delete();
    set_r(1'b1, 8'h99, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) begin
      settle();
      check("mid_rst_valid", r_o_valid, 0);
      check("mid_rst_ready", r_o_ready, 0);
      next();
    end
    reset_n = 1'b1;
    set_r(1'b0, 8'h00, 1'b1, 1'b0); settle();
    check("post_rst_count", r_count, 0);
    check("post_rst_ready", r_o_ready, 1);
    check("post_rst_valid", r_o_valid, 0);
    next(); next();

    // ---------------- fall-through instance ----------------
    set_f(1'b1, 8'h5C, 1'b1, 1'b1); settle();
    check("ft_valid", f_o_valid, 1);
    check("ft_data", f_o_data, 8'h5C);
    check("ft_count", f_count, 0);
    next();
    set_f(1'b1, 8'h6A, 1'b0, 1'b1); settle();
    check("ft_stall_count", f_count, 0);
    check("ft_stall_data", f_o_data, 8'h6A);
    next();
    set_f(1'b1, 8'h6B, 1'b0, 1'b1); settle();
    check("ft_stored_count", f_count, 1);
    check("ft_stored_data", f_o_data, 8'h6A);
    next();
    set_f(1'b0, 8'h00, 1'b1, 1'b0); settle();
    check("ft_drain_count2", f_count, 2);
    next(); settle();
    check("ft_drain_count1", f_count, 1);
    next(); settle();
    check("ft_drain_count0", f_count, 0);
    check("ft_idle_valid", f_o_valid, 0);
    next();
    flush = 1'b1;
    set_f(1'b1, 8'h77, 1'b1, 1'b0); settle();
    check("ft_flush_valid", f_o_valid, 0);
    check("ft_flush_ready", f_o_ready, 0);
    next();
    flush = 1'b0;
    set_f(1'b0, 8'h00, 1'b1, 1'b0); settle();
    check("ft_flush_count", f_count, 0);
    next(); next();

    check("r_queue_empty", rq.size(), 0);
    check("f_queue_empty", fq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
